// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, H/V counters, syncs and strobes.
// Latency: counters, syncs, video_on and strobes update together on the pixel-tick edge; all registered.
// No backpressure: free-running. Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
`timescale 1ns/1ps

module vga_timing_gen #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic             frame_start,
    output logic [15:0]      frame_cnt
`else
    output logic             frame_start
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             p_tick_q, p_tick_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // The tick is raised on the edge that loads div=CLK_DIV-1, so the strobe
    // and the counts it advances appear in the same clock cycle.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick  = (div_d == DIV_LAST);
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
    end

    // Decode from the next counts so syncs and video_on never lag the position.
    always_comb begin
        p_tick_d      = tick;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            hsync_d       = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
            video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
            line_start_d  = (x_d == '0);
            frame_start_d = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            p_tick_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            p_tick_q      <= p_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign p_tick      = p_tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default 640x480/div4, tiny div1, tiny div3 with
// active-high syncs) checked every cycle against a closed-form raster model, plus vectors and corner sequences.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    typedef struct packed {
        logic        p;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct packed {
        int div; int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        bit hp; bit vp;
    } cfg_t;

    localparam cfg_t CFG_A = '{div:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
    localparam cfg_t CFG_B = '{div:1, hd:8, hf:2, hs:4, hb:2, vd:4, vf:1, vs:2, vb:1, hp:1'b0, vp:1'b0};
    localparam cfg_t CFG_C = '{div:3, hd:8, hf:2, hs:4, hb:2, vd:4, vf:1, vs:2, vb:1, hp:1'b1, vp:1'b1};

    typedef struct {
        int e; int x; int y;
        bit hs; bit vs; bit vid; bit ls; bit fs;
        int fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic a_p, a_hs, a_vs, a_vid, a_ls, a_fs;
    logic b_p, b_hs, b_vs, b_vid, b_ls, b_fs;
    logic c_p, c_hs, c_vs, c_vid, c_ls, c_fs;
    logic [9:0] a_x, a_y, c_x, c_y;
    logic [3:0] b_x, b_y;
    logic [15:0] a_fc, b_fc, c_fc;
    obs_t obs_a, obs_b, obs_c;
    int e_a, e_b, e_c;
    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .p_tick(a_p), .pixel_x(a_x), .pixel_y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vid), .line_start(a_ls),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(a_fs), .frame_cnt(a_fc)
`else
        .frame_start(a_fs)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(b_p), .pixel_x(b_x), .pixel_y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vid), .line_start(b_ls),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(b_fs), .frame_cnt(b_fc)
`else
        .frame_start(b_fs)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(10)
    ) dut_c (
        .clk(clk), .reset(rst_c), .p_tick(c_p), .pixel_x(c_x), .pixel_y(c_y),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vid), .line_start(c_ls),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(c_fs), .frame_cnt(c_fc)
`else
        .frame_start(c_fs)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign a_fc = '0;
    assign b_fc = '0;
    assign c_fc = '0;
`endif

    always_comb begin
        obs_a = '{p:a_p, x:a_x, y:a_y, hs:a_hs, vs:a_vs, vid:a_vid, ls:a_ls, fs:a_fs, fc:a_fc};
        obs_b = '{p:b_p, x:10'(b_x), y:10'(b_y), hs:b_hs, vs:b_vs, vid:b_vid, ls:b_ls, fs:b_fs, fc:b_fc};
        obs_c = '{p:c_p, x:c_x, y:c_y, hs:c_hs, vs:c_vs, vid:c_vid, ls:c_ls, fs:c_fs, fc:c_fc};
    end

    // Clock edges seen with reset low since the last reset; cleared asynchronously like the DUT.
    always @(posedge clk or posedge rst_a) if (rst_a) e_a <= 0; else e_a <= e_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) e_b <= 0; else e_b <= e_b + 1;
    always @(posedge clk or posedge rst_c) if (rst_c) e_c <= 0; else e_c <= e_c + 1;

    // Raster position from pixel-tick count: ticks fall on edges where the divider reaches CLK_DIV-1.
    function automatic obs_t model(input int e, input cfg_t c);
        int ht, vt, t, x, y;
        obs_t o;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        t  = (c.div == 1) ? e : (e + 1) / c.div;
        x  = t % ht;
        y  = (t / ht) % vt;
        o  = '0;
        o.p  = (e > 0) && ((e % c.div) == (c.div - 1));
        o.hs = ~c.hp;
        o.vs = ~c.vp;
        if (t > 0) begin
            o.x   = 10'(x);
            o.y   = 10'(y);
            o.vid = (x < c.hd) && (y < c.vd);
            if (x >= c.hd + c.hf && x < c.hd + c.hf + c.hs) o.hs = c.hp;
            if (y >= c.vd + c.vf && y < c.vd + c.vf + c.vs) o.vs = c.vp;
        end
        o.ls = o.p && (x == 0);
        o.fs = o.ls && (y == 0);
`ifdef VGA_FRAME_CNT_EN
        o.fc = 16'(t / (ht * vt));
`endif
        return o;
    endfunction

    task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t got x=%0d y=%0d raw=%h want x=%0d y=%0d raw=%h",
                     nm, $time, got.x, got.y, got, exp.x, exp.y, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t got %0d want %0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_obs("model_a", obs_a, model(e_a, CFG_A));
            check_obs("model_b", obs_b, model(e_b, CFG_B));
            check_obs("model_c", obs_c, model(e_c, CFG_C));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        obs_t ex;
        int n, gap, ticks, hs_cnt, hs_min, hs_max, ls_cnt, fs_cnt, vid_cnt, vs_cnt, seq_err;
        bit seen, found;
        int k;

        tbl[0]  = '{0,   0,  0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1,   1,  0, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{7,   7,  0, 1, 1, 1, 0, 0, 0};
        tbl[3]  = '{8,   8,  0, 1, 1, 0, 0, 0, 0};
        tbl[4]  = '{10,  10, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{13,  13, 0, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{14,  14, 0, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{15,  15, 0, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{16,  0,  1, 1, 1, 1, 1, 0, 0};
        tbl[9]  = '{64,  0,  4, 1, 1, 0, 1, 0, 0};
        tbl[10] = '{80,  0,  5, 1, 0, 0, 1, 0, 0};
        tbl[11] = '{111, 15, 6, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{112, 0,  7, 1, 1, 0, 1, 0, 0};
        tbl[13] = '{128, 0,  0, 1, 1, 1, 1, 1, 1};
        tbl[14] = '{129, 1,  0, 1, 1, 1, 0, 0, 1};
        tbl[15] = '{139, 11, 0, 0, 1, 0, 0, 0, 1};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        chk_on = 1'b1;

        // Reset held: fixed reset values, idle syncs follow polarity.
        repeat (3) @(negedge clk);
        #1;
        check_obs("rst_a", obs_a, '{p:0, x:0, y:0, hs:1, vs:1, vid:0, ls:0, fs:0, fc:0});
        check_obs("rst_c", obs_c, '{p:0, x:0, y:0, hs:0, vs:0, vid:0, ls:0, fs:0, fc:0});
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Divide-by-4: first tick on the 3rd edge, then every 4th.
        n = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (a_p) begin seen = 1'b1; n = i; end
        end
        check_int("a_first_tick", n, 3);
        gap = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (a_p) begin seen = 1'b1; gap = i; end
        end
        check_int("a_tick_gap", gap, 4);

        // One full 800-pixel line on the default timing.
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        ticks = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; ls_cnt = 0; vid_cnt = 0; seq_err = 0;
        for (int i = 1; i <= 3199; i++) begin
            @(posedge clk); #1;
            if (a_p) begin
                ticks++;
                if (a_x != 10'(ticks % 800)) seq_err++;
                if (!a_hs) begin
                    hs_cnt++;
                    if (int'(a_x) < hs_min) hs_min = int'(a_x);
                    if (int'(a_x) > hs_max) hs_max = int'(a_x);
                end
                if (a_ls) ls_cnt++;
                if (a_vid) vid_cnt++;
            end
        end
        check_int("a_line_ticks", ticks, 800);
        check_int("a_line_seq", seq_err, 0);
        check_int("a_hs_count", hs_cnt, 96);
        check_int("a_hs_first", hs_min, 656);
        check_int("a_hs_last", hs_max, 751);
        check_int("a_line_start", ls_cnt, 1);
        check_int("a_video_cnt", vid_cnt, 640);
        check_int("a_y_after_wrap", int'(a_y), 1);

        // Vector table on the 16x8 raster, divide-by-1.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); rst_b = 1'b1;
            @(negedge clk); rst_b = 1'b0;
            repeat (tbl[i].e) @(posedge clk);
            #1;
            ex = '0;
            ex.p   = (tbl[i].e > 0);
            ex.x   = 10'(tbl[i].x);
            ex.y   = 10'(tbl[i].y);
            ex.hs  = tbl[i].hs;
            ex.vs  = tbl[i].vs;
            ex.vid = tbl[i].vid;
            ex.ls  = tbl[i].ls;
            ex.fs  = tbl[i].fs;
`ifdef VGA_FRAME_CNT_EN
            ex.fc  = 16'(tbl[i].fc);
`endif
            check_obs($sformatf("tbl%0d", i), obs_b, ex);
        end

        // One full frame on the 16x8 raster.
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        vs_cnt = 0; vid_cnt = 0; fs_cnt = 0; ls_cnt = 0;
        for (int i = 1; i <= 128; i++) begin
            @(posedge clk); #1;
            if (!b_vs) vs_cnt++;
            if (b_vid) vid_cnt++;
            if (b_fs) fs_cnt++;
            if (b_ls) ls_cnt++;
        end
        check_int("b_vs_count", vs_cnt, 32);
        check_int("b_video_cnt", vid_cnt, 32);
        check_int("b_frame_start", fs_cnt, 1);
        check_int("b_line_start", ls_cnt, 8);

        // Mid-frame asynchronous reset clears counters within the cycle.
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (b_x == 4'd5 && b_y == 4'd3) found = 1'b1;
        end
        check_int("b_reach_5_3", int'(found), 1);
        #2 rst_b = 1'b1;
        #1;
        check_obs("b_async_rst", obs_b, '{p:0, x:0, y:0, hs:1, vs:1, vid:0, ls:0, fs:0, fc:0});
        @(negedge clk); rst_b = 1'b0;

`ifdef VGA_FRAME_CNT_EN
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        repeat (384) @(posedge clk);
        #1;
        check_int("b_frame_cnt3", int'(b_fc), 3);
`endif

        // Active-high syncs on divide-by-3: same positions, inverted levels.
        @(negedge clk); rst_c = 1'b1;
        @(negedge clk); rst_c = 1'b0;
        ticks = 0; hs_cnt = 0; vs_cnt = 0; hs_min = 9999; hs_max = -1;
        for (int i = 1; i <= 384; i++) begin
            @(posedge clk); #1;
            if (c_p) begin
                ticks++;
                if (c_hs) begin
                    hs_cnt++;
                    if (int'(c_x) < hs_min) hs_min = int'(c_x);
                    if (int'(c_x) > hs_max) hs_max = int'(c_x);
                end
                if (c_vs) vs_cnt++;
            end
        end
        check_int("c_ticks", ticks, 128);
        check_int("c_hs_high", hs_cnt, 32);
        check_int("c_vs_high", vs_cnt, 32);
        check_int("c_hs_first", hs_min, 10);
        check_int("c_hs_last", hs_max, 13);

        // Random reset hits at arbitrary points; the per-cycle model checks everything.
        for (int it = 0; it < 25; it++) begin
            k = int'($urandom_range(0, 2));
            repeat ($urandom_range(1, 300)) @(negedge clk);
            #($urandom_range(1, 4));
            if (k == 0) rst_a = 1'b1; else if (k == 1) rst_b = 1'b1; else rst_c = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        end

        repeat (10) @(negedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
